// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory store path: size codes, FSM state codes
// and the alignment rule that decides whether a store can be performed.
package dm_pkg;

  typedef logic [1:0] size_t;
  typedef logic [1:0] state_t;

  localparam size_t SZ_WORD = 2'b00;
  localparam size_t SZ_HALF = 2'b01;
  localparam size_t SZ_BYTE = 2'b10;
  localparam size_t SZ_ILL  = 2'b11;

  localparam state_t ST_IDLE  = 2'b00;
  localparam state_t ST_READ  = 2'b01;
  localparam state_t ST_WRITE = 2'b10;
  localparam state_t ST_FAULT = 2'b11;

  // Illegal size code is treated as never aligned so it always faults.
  function automatic logic is_aligned(input size_t size, input logic [1:0] byte_off);
    logic ok;
    case (size)
      SZ_WORD: ok = (byte_off == 2'b00);
      SZ_HALF: ok = ~byte_off[0];
      SZ_BYTE: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Packs store data into an existing little-endian memory word; lanes not written
// by the store keep their old contents.
module store_lane_merge
  import dm_pkg::*;
(
  input  logic [31:0] old_i,
  input  logic [31:0] data_i,
  input  size_t       size_i,
  input  logic [1:0]  lane_i,
  output logic [31:0] merged_o
);

  always_comb begin
    merged_o = old_i;
    case (size_i)
      SZ_WORD: merged_o = data_i;
      SZ_HALF: begin
        if (lane_i[1]) merged_o[31:16] = data_i[15:0];
        else           merged_o[15:0]  = data_i[15:0];
      end
      SZ_BYTE: begin
        case (lane_i)
          2'd0:    merged_o[7:0]   = data_i[7:0];
          2'd1:    merged_o[15:8]  = data_i[7:0];
          2'd2:    merged_o[23:16] = data_i[7:0];
          default: merged_o[31:24] = data_i[7:0];
        endcase
      end
      default: merged_o = old_i;
    endcase
  end

endmodule

// File: rtl/dm_store_merge.sv
// Store-side data path for a word-only data memory: word stores write directly,
// half/byte stores read the word, merge the lane and write it back.
module dm_store_merge
  import dm_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [1:0]        req_size,
  output logic              stall,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  state_t            state_q, state_d;
  logic [ADDR_W+1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  size_t             size_q, size_d;
  logic [31:0]       merged;
  logic              in_write, in_fault;
  logic              unused_addr_bits;

  // Bits above the DM range are dropped, so addresses wrap around in the DM.
  assign unused_addr_bits = ^req_addr[31:ADDR_W+2];

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    size_d  = size_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d = req_addr[ADDR_W+1:0];
          data_d = req_wdata;
          size_d = req_size;
          if (!is_aligned(req_size, req_addr[1:0])) state_d = ST_FAULT;
          else if (req_size == SZ_WORD)             state_d = ST_WRITE;
          else                                      state_d = ST_READ;
        end
      end
      ST_READ:  state_d = ST_WRITE;
      ST_WRITE: state_d = ST_IDLE;
      ST_FAULT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      size_q  <= SZ_WORD;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      size_q  <= size_d;
    end
  end

  store_lane_merge u_merge (
    .old_i    (mem_rdata),
    .data_i   (data_q),
    .size_i   (size_q),
    .lane_i   (addr_q[1:0]),
    .merged_o (merged)
  );

  // Reset masks the terminal states so an interrupted store neither writes nor completes.
  assign in_write  = (state_q == ST_WRITE) && !reset;
  assign in_fault  = (state_q == ST_FAULT) && !reset;

  assign mem_we    = in_write;
  assign done      = in_write | in_fault;
  assign err       = in_fault;
  assign stall     = req_valid & ~done;
  assign mem_addr  = addr_q[ADDR_W+1:2];
  assign mem_wdata = in_write ? merged : 32'h0;

endmodule

// File: tb/tb_dm_store_merge.sv
// Self-checking bench for dm_store_merge: a word-array DM harness plus a
// behavioural memory-image model computed from the little-endian store rules.
module tb_dm_store_merge;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              reqValid = 1'b0;
  logic [31:0]       reqAddr = '0;
  logic [31:0]       reqWdata = '0;
  logic [1:0]        reqSize = '0;
  logic              stall, done, err, memWe;
  logic [ADDR_W-1:0] memAddr;
  logic [31:0]       memWdata;
  logic [31:0]       memRdata;

  logic [31:0]       dmMem    [DEPTH];
  logic [31:0]       modelMem [DEPTH];
  logic              clearMem = 1'b0;
  logic              pokeEn = 1'b0;
  logic [ADDR_W-1:0] pokeAddr = '0;
  logic [31:0]       pokeData = '0;

  int testCount = 0;
  int failCount = 0;

  always #5 clk = ~clk;

  dm_store_merge #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (reqValid),
    .req_addr  (reqAddr),
    .req_wdata (reqWdata),
    .req_size  (reqSize),
    .stall     (stall),
    .done      (done),
    .err       (err),
    .mem_addr  (memAddr),
    .mem_we    (memWe),
    .mem_wdata (memWdata),
    .mem_rdata (memRdata)
  );

  // DM harness: synchronous read, write-first when read and write hit together.
  always @(posedge clk) begin
    if (clearMem) begin
      for (int i = 0; i < DEPTH; i++) dmMem[i] <= '0;
      memRdata <= '0;
    end else begin
      if (memWe)       dmMem[memAddr]  <= memWdata;
      else if (pokeEn) dmMem[pokeAddr] <= pokeData;
      memRdata <= memWe ? memWdata : dmMem[memAddr];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  function automatic bit modelLegal(input logic [1:0] size, input logic [1:0] lo);
    if (size == 2'b00) return lo == 2'b00;
    if (size == 2'b01) return lo[0] == 1'b0;
    if (size == 2'b10) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] modelMerge(input logic [31:0] old, input logic [31:0] data,
                                             input logic [1:0] size, input logic [1:0] lo);
    logic [31:0] mask;
    int sh;
    if (size == 2'b00) return data;
    if (size == 2'b10) begin
      sh   = 8 * int'(lo);
      mask = 32'h0000_00FF << sh;
    end else begin
      sh   = 16 * int'(lo[1]);
      mask = 32'h0000_FFFF << sh;
    end
    return (old & ~mask) | ((data << sh) & mask);
  endfunction

  task automatic pokeWord(input int idx, input logic [31:0] data);
    pokeEn   = 1'b1;
    pokeAddr = ADDR_W'(idx);
    pokeData = data;
    @(posedge clk); #1;
    pokeEn   = 1'b0;
    modelMem[idx] = data;
  endtask

  // Issues one store, holds it until done (bounded) and checks timing, flags and written word.
  task automatic applyStimulus(input string name, input logic [31:0] addr, input logic [31:0] data,
                               input logic [1:0] size, input bit scramble);
    int          idx, expCyc, cyc, doneCyc;
    bit          legal, seenDone, sawStray;
    logic [31:0] expWord, gotAddr, gotWdata, rdAddr;
    logic        stall0, gotWe, gotErr, gotStall;
    idx      = int'(addr[ADDR_W+1:2]);
    legal    = modelLegal(size, addr[1:0]);
    expCyc   = (legal && size != 2'b00) ? 2 : 1;
    expWord  = modelMerge(modelMem[idx], data, size, addr[1:0]);
    reqValid = 1'b1;
    reqAddr  = addr;
    reqWdata = data;
    reqSize  = size;
    cyc = 0; doneCyc = -1; seenDone = 0; sawStray = 0;
    stall0 = 0; gotWe = 0; gotErr = 0; gotStall = 1; gotAddr = '0; gotWdata = '0; rdAddr = '0;
    while (!seenDone && cyc < 8) begin
      @(negedge clk);
      if (cyc == 0) stall0 = stall;
      if (done) begin
        seenDone = 1; doneCyc = cyc;
        gotWe = memWe; gotErr = err; gotStall = stall; gotAddr = 32'(memAddr); gotWdata = memWdata;
      end else begin
        if (memWe || err) sawStray = 1;
        if (cyc == 1) rdAddr = 32'(memAddr);
      end
      @(posedge clk); #1;
      if (scramble) begin
        reqWdata = $urandom;
        reqAddr  = $urandom;
        reqSize  = 2'($urandom);
      end
      cyc++;
    end
    reqValid = 1'b0;
    checkOutput({name, ".doneSeen"}, 32'(seenDone), 32'd1);
    checkOutput({name, ".latency"}, doneCyc, expCyc);
    checkOutput({name, ".stallCyc0"}, 32'(stall0), 32'd1);
    checkOutput({name, ".stallAtDone"}, 32'(gotStall), 32'd0);
    checkOutput({name, ".err"}, 32'(gotErr), 32'(!legal));
    checkOutput({name, ".memWe"}, 32'(gotWe), 32'(legal));
    checkOutput({name, ".strayWeErr"}, 32'(sawStray), 32'd0);
    if (legal) begin
      checkOutput({name, ".memAddr"}, gotAddr, idx);
      checkOutput({name, ".memWdata"}, gotWdata, expWord);
      if (expCyc == 2) checkOutput({name, ".readAddr"}, rdAddr, idx);
      modelMem[idx] = expWord;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int mism;
    logic [31:0] rAddr;
    for (int i = 0; i < DEPTH; i++) modelMem[i] = '0;
    reset = 1'b1;
    clearMem = 1'b1;
    repeat (3) @(posedge clk);
    #1 clearMem = 1'b0;
    @(negedge clk);
    checkOutput("rst.memAddr", 32'(memAddr), 32'd0);
    checkOutput("rst.memWdata", memWdata, 32'd0);
    checkOutput("rst.memWe", 32'(memWe), 32'd0);
    checkOutput("rst.done", 32'(done), 32'd0);
    checkOutput("rst.err", 32'(err), 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("idle.done", 32'(done), 32'd0);
    checkOutput("idle.stall", 32'(stall), 32'd0);
    @(posedge clk); #1;

    applyStimulus("sw10", 32'h10, 32'hDEADBEEF, 2'b00, 0);
    pokeWord(4, 32'h11223344);
    applyStimulus("sb12", 32'h12, 32'h000000AB, 2'b10, 0);
    pokeWord(4, 32'h11223344);
    applyStimulus("sh12", 32'h12, 32'h0000BEEF, 2'b01, 0);
    applyStimulus("sh10", 32'h10, 32'h00005566, 2'b01, 0);
    checkOutput("b2b.model", modelMem[4], 32'hBEEF5566);

    applyStimulus("shOdd", 32'h13, 32'hAAAA5555, 2'b01, 0);
    applyStimulus("swMis", 32'h12, 32'h01020304, 2'b00, 0);
    applyStimulus("szIll", 32'h14, 32'hFFFFFFFF, 2'b11, 0);

    reqValid = 1'b1; reqAddr = 32'h20; reqWdata = 32'h77; reqSize = 2'b10;
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    checkOutput("rstRead.memWe", 32'(memWe), 32'd0);
    checkOutput("rstRead.done", 32'(done), 32'd0);
    @(posedge clk); #1 reset = 1'b0; reqValid = 1'b0;
    @(negedge clk);
    checkOutput("rstRead.after", 32'({done, memWe, err}), 32'd0);
    @(posedge clk); #1;

    reqValid = 1'b1; reqAddr = 32'h40; reqWdata = 32'hCAFEF00D; reqSize = 2'b00;
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    checkOutput("rstWrite.memWe", 32'(memWe), 32'd0);
    checkOutput("rstWrite.done", 32'(done), 32'd0);
    @(posedge clk); #1 reset = 1'b0; reqValid = 1'b0;
    @(posedge clk); #1;

    applyStimulus("swAfterRst", 32'h44, 32'h0BADF00D, 2'b00, 0);
    applyStimulus("hold", 32'h31, 32'h12345678, 2'b10, 1);
    applyStimulus("wrap", 32'hFFFF_F008, 32'hA5A5A5A5, 2'b00, 0);

    for (int n = 0; n < 8; n++) begin
      rAddr = $urandom;
      rAddr[11:5] = '0;
      applyStimulus($sformatf("rnd%0d", n), rAddr, $urandom, 2'($urandom_range(0, 3)), 1'($urandom));
    end

    mism = 0;
    for (int i = 0; i < DEPTH; i++) if (dmMem[i] !== modelMem[i]) mism++;
    checkOutput("dmImage", mism, 0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
